// File: rtl/itch_pkg.sv
// Shared types and defaults for the ITCH receive frame sequencer.
// Header layout: Eth(14) + VLAN(4) + IPv4(20) + UDP(8) + MoldUDP64(20) = 66 bytes.
package itch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DROP
    } seqState_e;

    localparam int unsigned HDR_BEATS_DEF = 9;
    localparam int unsigned PAY_LANE_DEF  = 2;
    localparam int unsigned MAX_BEATS_DEF = 127;

    localparam int unsigned HDR_BYTES      = 66;
    localparam int unsigned ETH_DST_OFF    = 0;
    localparam int unsigned ETH_SRC_OFF    = 6;
    localparam int unsigned VLAN_TPID_OFF  = 12;
    localparam int unsigned VLAN_TCI_OFF   = 14;
    localparam int unsigned ETHERTYPE_OFF  = 16;
    localparam int unsigned IP_OFF         = 18;
    localparam int unsigned UDP_OFF        = 38;
    localparam int unsigned MOLD_SESS_OFF  = 46;
    localparam int unsigned MOLD_SEQ_OFF   = 56;
    localparam int unsigned MOLD_COUNT_OFF = 64;

endpackage

// File: rtl/itch_frame_sequencer_sat_counter16.sv
// 16-bit statistics counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/itch_frame_sequencer.sv
// Frame-aligned word index for the header decoders, payload hand-off to the
// message splitter, and short/truncated/oversize frame statistics.
module itch_frame_sequencer
    import itch_pkg::*;
#(
    parameter int unsigned HDR_BEATS = HDR_BEATS_DEF,
    parameter int unsigned PAY_LANE  = PAY_LANE_DEF,
    parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [63:0] rx_data_net,
    output logic [6:0]  counter,
    output logic        dec_en,
    output logic        hdr_done,
    output logic        pay_valid,
    output logic        pay_sop,
    output logic        pay_eop,
    output logic [2:0]  pay_lane,
    output logic [63:0] pay_data,
    output logic        frame_err,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_short,
    output logic [15:0] cnt_long
);

    localparam logic [6:0] LAST_HDR = 7'(HDR_BEATS - 1);
    localparam logic [6:0] MAX_IDX  = 7'(MAX_BEATS);

    seqState_e  state, stateNext;
    logic [6:0] beatQ, beatNext;
    logic       hdrDoneNext, frameErrNext;
    logic       payValidNext, paySopNext, payEopNext;
    logic [2:0] payLaneNext;
    logic       incOk, incShort, incLong;

    // Zero-latency index so decoders see it alongside rx_data_net.
    always_comb begin
        counter = (rx_valid && rx_sop) ? 7'd0 : beatQ;
        dec_en  = rx_valid && (rx_sop || (state == HEADER));
    end

    always_comb begin
        stateNext    = state;
        beatNext     = beatQ;
        hdrDoneNext  = 1'b0;
        frameErrNext = 1'b0;
        payValidNext = 1'b0;
        paySopNext   = 1'b0;
        payEopNext   = 1'b0;
        payLaneNext  = '0;
        incOk        = 1'b0;
        incShort     = 1'b0;
        incLong      = 1'b0;

        if (rx_valid) begin
            if (rx_sop) begin
                // An open frame is truncated; a payload stream gets an empty closing beat.
                if (state != IDLE) begin
                    frameErrNext = 1'b1;
                    incShort     = 1'b1;
                    if (state == PAYLOAD) begin
                        payValidNext = 1'b1;
                        payEopNext   = 1'b1;
                    end
                end
                if (rx_eop) begin
                    frameErrNext = 1'b1;
                    incShort     = 1'b1;
                    stateNext    = IDLE;
                    beatNext     = '0;
                end else begin
                    stateNext = HEADER;
                    beatNext  = 7'd1;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    HEADER: begin
                        if (counter == LAST_HDR) begin
                            hdrDoneNext = 1'b1;
                            if (rx_eop) begin
                                incOk     = 1'b1;
                                stateNext = IDLE;
                                beatNext  = '0;
                            end else begin
                                payValidNext = 1'b1;
                                paySopNext   = 1'b1;
                                payLaneNext  = 3'(PAY_LANE);
                                stateNext    = PAYLOAD;
                                beatNext     = counter + 7'd1;
                            end
                        end else if (rx_eop) begin
                            frameErrNext = 1'b1;
                            incShort     = 1'b1;
                            stateNext    = IDLE;
                            beatNext     = '0;
                        end else begin
                            beatNext = counter + 7'd1;
                        end
                    end
                    PAYLOAD: begin
                        payValidNext = 1'b1;
                        if (rx_eop) begin
                            payEopNext = 1'b1;
                            incOk      = 1'b1;
                            stateNext  = IDLE;
                            beatNext   = '0;
                        end else if (counter == MAX_IDX) begin
                            payEopNext   = 1'b1;
                            frameErrNext = 1'b1;
                            incLong      = 1'b1;
                            stateNext    = DROP;
                            beatNext     = counter + 7'd1;
                        end else begin
                            beatNext = counter + 7'd1;
                        end
                    end
                    DROP: begin
                        if (rx_eop) begin
                            stateNext = IDLE;
                            beatNext  = '0;
                        end
                    end
                    default: begin
                        stateNext = IDLE;
                        beatNext  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beatQ     <= '0;
            hdr_done  <= 1'b0;
            frame_err <= 1'b0;
            pay_valid <= 1'b0;
            pay_sop   <= 1'b0;
            pay_eop   <= 1'b0;
            pay_lane  <= '0;
            pay_data  <= '0;
        end else begin
            state     <= stateNext;
            beatQ     <= beatNext;
            hdr_done  <= hdrDoneNext;
            frame_err <= frameErrNext;
            pay_valid <= payValidNext;
            pay_sop   <= paySopNext;
            pay_eop   <= payEopNext;
            pay_lane  <= payLaneNext;
            if (payValidNext) begin
                pay_data <= rx_data_net;
            end
        end
    end

    sat_counter16 uOkCnt    (.clk(clk), .rst(rst), .inc(incOk),    .count(cnt_ok));
    sat_counter16 uShortCnt (.clk(clk), .rst(rst), .inc(incShort), .count(cnt_short));
    sat_counter16 uLongCnt  (.clk(clk), .rst(rst), .inc(incLong),  .count(cnt_long));

endmodule

// File: tb/tb_itch_frame_sequencer.sv
// Scoreboard bench for itch_frame_sequencer: driver pushes expected payload
// beats, a negedge monitor pops and compares them against the DUT stream.
module tb_itch_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic [63:0] rx_data_net = '0;
    logic [6:0]  counter;
    logic        dec_en, hdr_done, pay_valid, pay_sop, pay_eop, frame_err;
    logic [2:0]  pay_lane;
    logic [63:0] pay_data;
    logic [15:0] cnt_ok, cnt_short, cnt_long;

    typedef struct {
        bit        sop;
        bit        eop;
        bit [2:0]  lane;
        bit [63:0] data;
        bit        care;
    } payExp_t;

    payExp_t sb[$];
    int nVec = 0;
    int nMis = 0;
    int hdrSeen = 0;
    int errSeen = 0;
    int hdr0, err0;

    itch_frame_sequencer #(.HDR_BEATS(9), .PAY_LANE(2), .MAX_BEATS(127)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_data_net(rx_data_net), .counter(counter), .dec_en(dec_en),
        .hdr_done(hdr_done), .pay_valid(pay_valid), .pay_sop(pay_sop),
        .pay_eop(pay_eop), .pay_lane(pay_lane), .pay_data(pay_data),
        .frame_err(frame_err), .cnt_ok(cnt_ok), .cnt_short(cnt_short),
        .cnt_long(cnt_long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] D(input int f, input int i);
        return {32'hCAFE0000 | 32'(f), 32'(i)};
    endfunction

    function automatic void push(input bit sop, input bit eop, input bit [2:0] lane,
                                 input bit [63:0] data, input bit care);
        payExp_t e;
        e.sop = sop; e.eop = eop; e.lane = lane; e.data = data; e.care = care;
        sb.push_back(e);
    endfunction

    task automatic beat(input bit sop, input bit eop, input logic [63:0] d,
                        input int expCnt, input bit expDec);
        @(negedge clk);
        rx_valid = 1'b1; rx_sop = sop; rx_eop = eop; rx_data_net = d;
        #1;
        chk("counter", 64'(counter), 64'(expCnt));
        chk("dec_en", 64'(dec_en), 64'(expDec));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        end
    endtask

    task automatic mark();
        hdr0 = hdrSeen;
        err0 = errSeen;
    endtask

    task automatic pulses(input string tag, input int hdrExp, input int errExp);
        chk({tag, " hdr_done pulses"}, 64'(hdrSeen - hdr0), 64'(hdrExp));
        chk({tag, " frame_err pulses"}, 64'(errSeen - err0), 64'(errExp));
    endtask

    task automatic stats(input string tag, input int ok, input int sh, input int lg);
        chk({tag, " cnt_ok"}, 64'(cnt_ok), 64'(ok));
        chk({tag, " cnt_short"}, 64'(cnt_short), 64'(sh));
        chk({tag, " cnt_long"}, 64'(cnt_long), 64'(lg));
    endtask

    task automatic resetValues(input string tag);
        chk({tag, " counter"}, 64'(counter), 64'd0);
        chk({tag, " dec_en"}, 64'(dec_en), 64'd0);
        chk({tag, " hdr_done"}, 64'(hdr_done), 64'd0);
        chk({tag, " frame_err"}, 64'(frame_err), 64'd0);
        chk({tag, " pay_valid"}, 64'(pay_valid), 64'd0);
        chk({tag, " pay_sop"}, 64'(pay_sop), 64'd0);
        chk({tag, " pay_eop"}, 64'(pay_eop), 64'd0);
        chk({tag, " pay_lane"}, 64'(pay_lane), 64'd0);
        chk({tag, " pay_data"}, pay_data, 64'd0);
        stats(tag, 0, 0, 0);
    endtask

    task automatic frame12(input int id);
        for (int i = 0; i < 12; i++) begin
            if (i >= 8) push(i == 8, i == 11, (i == 8) ? 3'd2 : 3'd0, D(id, i), 1'b1);
            beat(i == 0, i == 11, D(id, i), i, i <= 8);
        end
    endtask

    // Monitor: payload beats against the scoreboard, plus pulse counting.
    always @(negedge clk) begin
        if (!rst) begin
            if (hdr_done) hdrSeen++;
            if (frame_err) errSeen++;
            if (pay_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected pay_valid", 64'd1, 64'd0);
                end else begin
                    payExp_t e;
                    e = sb.pop_front();
                    chk("pay_sop", 64'(pay_sop), 64'(e.sop));
                    chk("pay_eop", 64'(pay_eop), 64'(e.eop));
                    chk("pay_lane", 64'(pay_lane), 64'(e.lane));
                    if (e.care) chk("pay_data", pay_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        resetValues("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // 12-beat frame: header 0..8, payload sop at 8 with lane 2, eop at 11
        mark();
        frame12(1);
        idle(3);
        pulses("f12", 1, 0);
        stats("f12", 1, 0, 0);

        // 9-beat heartbeat: header only
        mark();
        for (int i = 0; i < 9; i++) beat(i == 0, i == 8, D(2, i), i, 1'b1);
        idle(3);
        pulses("heartbeat", 1, 0);
        stats("heartbeat", 2, 0, 0);

        // 5-beat short frame
        mark();
        for (int i = 0; i < 5; i++) beat(i == 0, i == 4, D(3, i), i, 1'b1);
        idle(3);
        pulses("short", 0, 1);
        stats("short", 2, 1, 0);

        // Sop at beat 10 of an open frame: closing empty eop, restart at 0
        mark();
        for (int i = 0; i < 10; i++) begin
            if (i >= 8) push(i == 8, 1'b0, (i == 8) ? 3'd2 : 3'd0, D(4, i), 1'b1);
            beat(i == 0, 1'b0, D(4, i), i, i <= 8);
        end
        push(1'b0, 1'b1, 3'd0, 64'd0, 1'b0);
        beat(1'b1, 1'b0, D(5, 0), 0, 1'b1);
        for (int i = 1; i < 12; i++) begin
            if (i >= 8) push(i == 8, i == 11, (i == 8) ? 3'd2 : 3'd0, D(5, i), 1'b1);
            beat(1'b0, i == 11, D(5, i), i, i <= 8);
        end
        idle(3);
        pulses("trunc", 2, 1);
        stats("trunc", 3, 2, 0);

        // 130-beat frame: forced eop at 127, then 128..129 dropped (index wraps to 0)
        mark();
        for (int i = 0; i < 130; i++) begin
            if (i >= 8 && i <= 127)
                push(i == 8, i == 127, (i == 8) ? 3'd2 : 3'd0, D(6, i), 1'b1);
            beat(i == 0, i == 129, D(6, i), (i <= 127) ? i : 0, i <= 8);
        end
        idle(3);
        pulses("long", 1, 1);
        stats("long", 3, 2, 1);
        mark();
        frame12(7);
        idle(3);
        pulses("after long", 1, 0);
        stats("after long", 4, 2, 1);

        // Reset in the middle of a header, then a fresh frame
        for (int i = 0; i < 6; i++) beat(i == 0, 1'b0, D(8, i), i, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rst = 1'b1;
        #1;
        resetValues("mid-reset");
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        mark();
        frame12(9);
        idle(3);
        pulses("post-reset", 1, 0);
        stats("post-reset", 1, 0, 0);

        idle(2);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/itch_frame_sequencer.md
# itch_frame_sequencer

Frame-aligned sequencer for the ITCH receive header decoders. It tracks frame boundaries on the 64-bit receive word stream and drives the shared `counter` word index to the Ethernet, IP, UDP and MoldUDP64 decoders so that index 0 always lands on the first word of a frame. It gates decoder capture, flags short, truncated and oversize frames, and hands the post-header payload to the downstream ITCH message splitter. It replaces the free-running word counter in the parser top level.

## Interface
Parameters:
- `HDR_BEATS`, 9: beats carrying Eth+VLAN/IP/UDP/MoldUDP64 headers (66 bytes), indices 0..8.
- `PAY_LANE`, 2: first payload byte lane in beat `HDR_BEATS-1`.
- `MAX_BEATS`, 127: largest legal beat index; must fit the 7-bit counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `rx_valid` in 1: beat valid.
- `rx_sop` in 1: first beat of frame; qualified by `rx_valid`.
- `rx_eop` in 1: last beat of frame; qualified by `rx_valid`.
- `rx_data_net` in 64: beat data.
- `counter` out 7: word index of the current beat, to the decoders.
- `dec_en` out 1: decoders may capture this cycle.
- `hdr_done` out 1: one-cycle pulse; header fields are complete and stable.
- `pay_valid`, `pay_sop`, `pay_eop` out 1 each: payload stream.
- `pay_lane` out 3: first valid lane; `PAY_LANE` on the `pay_sop` beat, else 0.
- `pay_data` out 64: payload beat.
- `frame_err` out 1: one-cycle pulse for a short, truncated or oversize frame.
- `cnt_ok`, `cnt_short`, `cnt_long` out 16 each: saturating frame statistics.

## Operation
- States: IDLE, HEADER, PAYLOAD, DROP.
- Beat index:
  - Internal `beat_q` is 7 bits.
  - `counter = (rx_valid && rx_sop) ? 0 : beat_q`.
  - `beat_q` becomes `counter+1` on each accepted beat in HEADER or PAYLOAD.
  - `beat_q` returns to 0 on eop or on entering IDLE.
- IDLE:
  - Non-sop beats are ignored.
  - A valid sop moves to HEADER (or completes the frame at once if sop and eop arrive together; that counts as short).
- HEADER:
  - `dec_en = rx_valid`.
  - Eop with `counter < HDR_BEATS-1` gives a short frame: `frame_err`, `cnt_short++`, go to IDLE.
  - Beat `HDR_BEATS-1` accepted:
    - If it is also eop: heartbeat frame, `hdr_done`, `cnt_ok++`, go to IDLE, no payload emitted.
    - Otherwise: `hdr_done`, emit it as a `pay_sop` beat with `pay_lane=PAY_LANE`, go to PAYLOAD.
- PAYLOAD:
  - `dec_en = 0`.
  - Each valid beat is forwarded.
  - Eop gives `pay_eop`, `cnt_ok++`, go to IDLE.
  - A valid beat at `counter == MAX_BEATS` without eop: `frame_err`, `cnt_long++`, forced `pay_eop` on that beat, go to DROP.
- DROP: `pay_valid = 0` and `dec_en = 0` until an eop beat, then go to IDLE.
- A sop arriving in HEADER, PAYLOAD or DROP means the previous frame was truncated:
  - Pulse `frame_err` and increment `cnt_short`.
  - If in PAYLOAD, the previous payload beat carried no eop, so assert `pay_eop` on an empty-closing cycle: `pay_valid=1`, data don't-care, `pay_lane=0`.
  - Restart the new frame at index 0 in HEADER in the same cycle (`dec_en=1`).
- Statistics counters saturate at 0xFFFF and never wrap.

## Timing
- `counter` and `dec_en` are combinational from `rx_valid`, `rx_sop` and state, so they align with `rx_data_net` in the same cycle (zero latency).
- `pay_*` outputs, `hdr_done`, `frame_err` and the statistics are registered: one cycle after the causing beat.
- `hdr_done` rises the cycle after beat `HDR_BEATS-1`. Decoders have captured that beat on the same edge, so fields are valid when `hdr_done` is high.
- Reset values:
  - State IDLE, `beat_q=0`, so `counter=0`.
  - `dec_en=0`, `hdr_done=0`, `frame_err=0`.
  - `pay_valid`, `pay_sop`, `pay_eop` = 0, `pay_lane=0`, `pay_data=0`.
  - All statistics counters 0.
- Reset mid-frame aborts the frame immediately. No `pay_eop` is emitted and no counter is updated.
- No backpressure: the input is never stalled and the payload consumer must accept every beat.

## Structure
- `itch_pkg`: state enum, `HDR_BEATS`, `PAY_LANE`, `MAX_BEATS` defaults, the header byte offsets (66-byte header, VLAN-tagged).
- One sub-module, `sat_counter16`, instantiated three times for the statistics.

## Test plan
- 12-beat frame (sop at beat 0, eop at beat 11) -> `counter` runs 0..11, `dec_en` high for beats 0..8, `hdr_done` the cycle after beat 8, `pay_sop` with `pay_lane=2` plus 3 payload beats, `pay_eop` on the last, `cnt_ok=1`.
- 9-beat heartbeat frame (eop on beat 8) -> `hdr_done` pulse, no `pay_valid`, `cnt_ok=1`.
- 5-beat frame -> `frame_err`, `cnt_short=1`, no `hdr_done`, next sop starts at `counter=0`.
- Sop at beat 10 of an open frame -> `frame_err`, closing `pay_eop`, new frame counted from 0, `cnt_short=1`.
- 130-beat frame -> forced `pay_eop` at index 127, `frame_err`, `cnt_long=1`, beats 128..129 dropped, following frame decodes normally.
- `rst` asserted at beat 6, then a fresh 12-beat frame -> all outputs at reset values, counters 0, fresh frame decodes correctly.
